// File: rtl/port_channel.sv
// rtl/port_channel.sv - CPU port-bus responder bridging a 4-word register window to TX/RX stream FIFOs.
// Optional feature: PORT_CHANNEL_LOOPBACK_EN enables the CTRL loopback path.
module port_channel #(
    parameter int                   WORD_SIZE  = 16,
    parameter logic [WORD_SIZE-1:0] BASE_ADDR  = 16'hFF00,
    parameter int                   DEPTH_LOG2 = 3
) (
    input  logic                 clk,
    input  logic                 do_reset,
    input  logic [WORD_SIZE-1:0] portaddr,
    input  logic [WORD_SIZE-1:0] portval,
    input  logic                 portget,
    input  logic                 portset,
    output logic [WORD_SIZE-1:0] portout,
    output logic                 hit,
    output logic [WORD_SIZE-1:0] tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    input  logic [WORD_SIZE-1:0] rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CLEAR  = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;

    logic [WORD_SIZE-1:0]  tx_mem [DEPTH];
    logic [WORD_SIZE-1:0]  rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_rd, tx_wr, rx_rd, rx_wr;
    logic [CW-1:0]         tx_count, rx_count;
    logic                  tx_overflow, rx_underflow;

    logic                  in_win;
    logic [1:0]            offset;
    logic                  tx_full, tx_empty, rx_full, rx_empty;
    logic                  tx_push_req, tx_push, tx_pop;
    logic                  rx_pop_req, rx_pop, rx_push;
    logic                  clear_wr, move;
    logic                  loop;
    logic [WORD_SIZE-1:0]  rx_wdata;
    logic [15:0]           status16;
    logic [WORD_SIZE+15:0] status_ext;
    logic [WORD_SIZE-1:0]  status_val;
    logic [WORD_SIZE-1:0]  ctrl_val;

    function automatic logic [3:0] cnt4(input logic [CW-1:0] c);
        logic [CW+3:0] w;
        w = {4'b0000, c};
        return w[3:0];
    endfunction

    assign in_win = (portaddr[WORD_SIZE-1:2] == BASE_ADDR[WORD_SIZE-1:2]);
    assign offset = portaddr[1:0];
    assign hit    = in_win && (portget || portset);

    assign tx_full  = (tx_count == CW'(DEPTH));
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == CW'(DEPTH));
    assign rx_empty = (rx_count == '0);

`ifdef PORT_CHANNEL_LOOPBACK_EN
    logic ctrl_wr;
    assign ctrl_wr = portset && in_win && (offset == OFF_CTRL);

    always_ff @(posedge clk) begin
        if (do_reset) begin
            loop <= 1'b0;
        end else if (ctrl_wr) begin
            loop <= portval[0];
        end
    end
`else
    assign loop = 1'b0;
`endif

    // In loopback the external handshakes are masked and the TX head feeds RX directly.
    assign move     = loop && !tx_empty && !rx_full && !do_reset;
    assign tx_valid = !tx_empty && !do_reset && !loop;
    assign rx_ready = !rx_full && !do_reset && !loop;
    assign tx_data  = tx_mem[tx_rd];
    assign rx_wdata = loop ? tx_mem[tx_rd] : rx_data;
    assign ctrl_val = {{(WORD_SIZE-1){1'b0}}, loop};

    assign tx_push_req = portset && in_win && (offset == OFF_DATA);
    assign tx_pop      = (tx_valid && tx_ready) || move;
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);

    assign rx_pop_req  = portget && in_win && (offset == OFF_DATA);
    assign rx_pop      = rx_pop_req && !rx_empty;
    assign rx_push     = (rx_valid && rx_ready) || move;

    assign clear_wr    = portset && in_win && (offset == OFF_CLEAR);

    assign status16   = {2'b00, rx_underflow, tx_overflow, cnt4(rx_count), cnt4(tx_count),
                         rx_full, rx_empty, tx_empty, tx_full};
    assign status_ext = {{WORD_SIZE{1'b0}}, status16};
    assign status_val = status_ext[WORD_SIZE-1:0];

    always_comb begin
        portout = '0;
        if (portget && in_win) begin
            case (offset)
                OFF_DATA:   portout = rx_empty ? '0 : rx_mem[rx_rd];
                OFF_STATUS: portout = status_val;
                OFF_CTRL:   portout = ctrl_val;
                default:    portout = '0;
            endcase
        end
    end

    // Storage is not reset; pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr] <= portval;
        end
        if (rx_push) begin
            rx_mem[rx_wr] <= rx_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (do_reset) begin
            tx_rd        <= '0;
            tx_wr        <= '0;
            rx_rd        <= '0;
            rx_wr        <= '0;
            tx_count     <= '0;
            rx_count     <= '0;
            tx_overflow  <= 1'b0;
            rx_underflow <= 1'b0;
        end else begin
            if (tx_push) begin
                tx_wr <= tx_wr + DEPTH_LOG2'(1);
            end
            if (tx_pop) begin
                tx_rd <= tx_rd + DEPTH_LOG2'(1);
            end
            tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);

            if (rx_push) begin
                rx_wr <= rx_wr + DEPTH_LOG2'(1);
            end
            if (rx_pop) begin
                rx_rd <= rx_rd + DEPTH_LOG2'(1);
            end
            rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);

            // A set on the same edge as a clear takes priority.
            if (tx_push_req && tx_full && !tx_pop) begin
                tx_overflow <= 1'b1;
            end else if (clear_wr && portval[12]) begin
                tx_overflow <= 1'b0;
            end
            if (rx_pop_req && rx_empty) begin
                rx_underflow <= 1'b1;
            end else if (clear_wr && portval[13]) begin
                rx_underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_port_channel.sv
// tb/tb_port_channel.sv - directed self-checking bench for port_channel.
module tb_port_channel;

    logic        clk = 1'b0;
    logic        do_reset;
    logic [15:0] portaddr, portval, portout;
    logic        portget, portset, hit;
    logic [15:0] tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, rx_ready;

    int checks = 0;
    int errors = 0;

    port_channel dut (
        .clk      (clk),
        .do_reset (do_reset),
        .portaddr (portaddr),
        .portval  (portval),
        .portget  (portget),
        .portset  (portset),
        .portout  (portout),
        .hit      (hit),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_out(input logic [15:0] addr, input logic [15:0] val);
        portaddr = addr;
        portval  = val;
        portset  = 1'b1;
        tick();
        portset  = 1'b0;
    endtask

    task automatic do_in(input logic [15:0] addr, input logic [15:0] exp, input string tag);
        portaddr = addr;
        portget  = 1'b1;
        #1;
        check(tag, portout, exp);
        tick();
        portget  = 1'b0;
    endtask

    logic [15:0] exp_q [8];

    initial begin
        do_reset = 1'b1;
        portaddr = '0;
        portval  = '0;
        portget  = 1'b0;
        portset  = 1'b0;
        tx_ready = 1'b0;
        rx_data  = '0;
        rx_valid = 1'b0;
        tick();
        tick();
        check("reset_tx_valid", {15'd0, tx_valid}, 16'd0);
        check("reset_rx_ready", {15'd0, rx_ready}, 16'd0);
        do_reset = 1'b0;
        tick();
        check("post_tx_valid", {15'd0, tx_valid}, 16'd0);
        check("post_rx_ready", {15'd0, rx_ready}, 16'd1);
        check("post_portout", portout, 16'd0);
        check("post_hit_idle", {15'd0, hit}, 16'd0);

        portaddr = 16'hFF01;
        portget  = 1'b1;
        #1;
        check("status_hit", {15'd0, hit}, 16'd1);
        tick();
        portget = 1'b0;
        do_in(16'hFF01, 16'h0006, "status_reset");

        do_out(16'hFF00, 16'h1111);
        do_out(16'hFF00, 16'h2222);
        do_out(16'hFF00, 16'h3333);
        do_in(16'hFF01, 16'h0034, "status_tx3");
        check("tx_valid_3", {15'd0, tx_valid}, 16'd1);
        tx_ready = 1'b1;
        check("tx_data_0", tx_data, 16'h1111);
        tick();
        check("tx_data_1", tx_data, 16'h2222);
        tick();
        check("tx_data_2", tx_data, 16'h3333);
        tick();
        check("tx_drained", {15'd0, tx_valid}, 16'd0);
        tx_ready = 1'b0;

        for (int i = 0; i < 9; i++) begin
            do_out(16'hFF00, 16'h0100 + 16'(i));
        end
        do_in(16'hFF01, 16'h1085, "status_overflow");
        check("tx_head_full", tx_data, 16'h0100);
        do_out(16'hFF02, 16'h1000);
        do_in(16'hFF01, 16'h0085, "status_ovf_clear");

        tx_ready = 1'b1;
        do_out(16'hFF00, 16'h0200);
        tx_ready = 1'b0;
        do_in(16'hFF01, 16'h0085, "status_full_pushpop");
        for (int i = 0; i < 7; i++) begin
            exp_q[i] = 16'h0101 + 16'(i);
        end
        exp_q[7] = 16'h0200;
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("tx_wrap_%0d", i), tx_data, exp_q[i]);
            tick();
        end
        check("tx_wrap_empty", {15'd0, tx_valid}, 16'd0);
        tx_ready = 1'b0;

        rx_data  = 16'hABCD;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        do_in(16'hFF00, 16'hABCD, "rx_pop_abcd");
        do_in(16'hFF00, 16'h0000, "rx_underflow_data");
        do_in(16'hFF01, 16'h2006, "status_underflow");
        do_out(16'hFF02, 16'h2000);
        do_in(16'hFF01, 16'h0006, "status_unf_clear");

        rx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rx_data = 16'h0300 + 16'(i);
            tick();
        end
        check("rx_full_ready", {15'd0, rx_ready}, 16'd0);
        rx_data = 16'h03FF;
        do_in(16'hFF01, 16'h080A, "status_rx_full");
        do_in(16'hFF00, 16'h0300, "rx_pop_full");
        check("rx_ready_after_pop", {15'd0, rx_ready}, 16'd1);
        tick();
        check("rx_refull_ready", {15'd0, rx_ready}, 16'd0);
        rx_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            exp_q[i] = 16'h0301 + 16'(i);
        end
        exp_q[7] = 16'h03FF;
        for (int i = 0; i < 8; i++) begin
            do_in(16'hFF00, exp_q[i], $sformatf("rx_drain_%0d", i));
        end
        do_in(16'hFF01, 16'h0006, "status_rx_drained");

        rx_data  = 16'h0400;
        rx_valid = 1'b1;
        tick();
        rx_data  = 16'h0401;
        do_in(16'hFF00, 16'h0400, "rx_pushpop_old_head");
        rx_valid = 1'b0;
        do_in(16'hFF01, 16'h0102, "status_rx_pushpop");
        do_in(16'hFF00, 16'h0401, "rx_pushpop_new");

        do_out(16'hFF01, 16'hFFFF);
        do_in(16'hFF01, 16'h0006, "status_write_ignored");
        do_in(16'hFF02, 16'h0000, "clear_reads_zero");

        portaddr = 16'hFF04;
        portget  = 1'b1;
        #1;
        check("miss_hi_portout", portout, 16'd0);
        check("miss_hi_hit", {15'd0, hit}, 16'd0);
        portaddr = 16'hFEFF;
        #1;
        check("miss_lo_hit", {15'd0, hit}, 16'd0);
        portget = 1'b0;
        tick();

`ifdef PORT_CHANNEL_LOOPBACK_EN
        do_out(16'hFF03, 16'h0001);
        do_in(16'hFF03, 16'h0001, "ctrl_loop_read");
        check("loop_rx_ready", {15'd0, rx_ready}, 16'd0);
        do_out(16'hFF00, 16'h5A5A);
        check("loop_tx_valid_a", {15'd0, tx_valid}, 16'd0);
        tick();
        check("loop_tx_valid_b", {15'd0, tx_valid}, 16'd0);
        do_in(16'hFF00, 16'h5A5A, "loop_rx_word");
`else
        do_out(16'hFF03, 16'h0001);
        do_in(16'hFF03, 16'h0000, "ctrl_reads_zero");
        do_out(16'hFF00, 16'h5A5A);
        check("noloop_tx_valid", {15'd0, tx_valid}, 16'd1);
        check("noloop_tx_data", tx_data, 16'h5A5A);
`endif

        do_out(16'hFF00, 16'h7777);
        rx_data  = 16'h8888;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        do_reset = 1'b1;
        tick();
        check("midreset_tx_valid", {15'd0, tx_valid}, 16'd0);
        check("midreset_rx_ready", {15'd0, rx_ready}, 16'd0);
        do_reset = 1'b0;
        #1;
        check("after_reset_rx_ready", {15'd0, rx_ready}, 16'd1);
        do_in(16'hFF01, 16'h0006, "status_after_reset");
        do_in(16'hFF03, 16'h0000, "ctrl_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
